// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
package shift_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        FIN   = 2'b10
    } shift_state_t;

    typedef struct packed {
        shift_op_t            op;
        logic [SHAMT_W-1:0]   shamt;
        logic [WIDTH-1:0]     din;
    } shift_req_t;

endpackage

// File: rtl/shift_seq_if.sv
// Request/response bundle between control and the shift sequencer.
interface shift_seq_if;
    import shift_pkg::*;

    logic              start;
    shift_req_t        req;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  dout;

    modport master (output start, req, input busy, done, dout);
    modport slave  (input start, req, output busy, done, dout);

endinterface

// File: rtl/shift_seq_step.sv
// One shift step of up to STEP bits with the fill selected by the op.
module shift_step
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0]   acc_i,
    input  shift_op_t          op_i,
    input  logic [SHAMT_W-1:0] amt_i,
    output logic [WIDTH-1:0]   res_o_c
);

    // SRA fills with the current MSB, which never changes across steps.
    always_comb begin
        res_o_c = acc_i;
        case (op_i)
            OP_SLL:  res_o_c = acc_i << amt_i;
            OP_SRL:  res_o_c = acc_i >> amt_i;
            OP_SRA:  res_o_c = WIDTH'($signed(acc_i) >>> amt_i);
            default: res_o_c = acc_i;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle SLL/SRL/SRA sequencer: latches operands on start, shifts STEP
// bits per cycle, then presents a registered result with a one-cycle done.
module shift_seq
    import shift_pkg::*;
#(
    parameter int unsigned STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    shift_seq_if.slave  bus
);

    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

    shift_state_t        state_q, state_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    shift_op_t           op_q, op_d;
    logic [WIDTH-1:0]    dout_q, dout_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [SHAMT_W-1:0]  step_amt_c;
    logic [WIDTH-1:0]    step_res_c;

    shift_step u_step (
        .acc_i   (acc_q),
        .op_i    (op_q),
        .amt_i   (step_amt_c),
        .res_o_c (step_res_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= OP_SLL;
            dout_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Final partial step uses the remaining count rather than STEP.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
        step_amt_c = (cnt_q < STEP_AMT) ? cnt_q : STEP_AMT;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.req.din;
                    cnt_d   = bus.req.shamt;
                    op_d    = bus.req.op;
                    state_d = (bus.req.shamt != '0 && bus.req.op != OP_RSV) ? SHIFT : FIN;
                end
            end
            SHIFT: begin
                acc_d = step_res_c;
                cnt_d = cnt_q - step_amt_c;
                if (cnt_q == step_amt_c) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                dout_d  = acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dout = dout_q;

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: three step sizes driven in parallel against a
// cycle-count/arithmetic reference model, plus literal directed checks.
module tb_shift_seq;
    import shift_pkg::*;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s = 1'b0;
    logic [1:0]  op_s = 2'b00;
    logic [31:0] din_s = '0;
    logic [4:0]  shamt_s = '0;

    logic        busy_a [NDUT];
    logic        done_a [NDUT];
    logic [31:0] dout_a [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic int unsigned step_of(int g);
        return (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        shift_seq_if u_if ();
        assign u_if.start = start_s;
        assign u_if.req   = '{op: shift_op_t'(op_s), shamt: shamt_s, din: din_s};
        assign busy_a[g]  = u_if.busy;
        assign done_a[g]  = u_if.done;
        assign dout_a[g]  = u_if.dout;
        shift_seq #(.STEP(step_of(g))) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if)
        );
    end

    // Reference model: remaining busy cycles and pending result per DUT.
    int          m_left [NDUT];
    logic [31:0] m_pend [NDUT];
    logic [31:0] m_dout [NDUT];
    logic        m_done [NDUT];

    function automatic logic [31:0] ref_res(logic [1:0] op, logic [31:0] d, logic [4:0] sh);
        logic [63:0] ext;
        case (op)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b10: begin
                ext = {{32{d[31]}}, d} >> sh;
                return ext[31:0];
            end
            default: return d;
        endcase
    endfunction

    task automatic model_step();
        int n;
        for (int g = 0; g < NDUT; g++) begin
            if (rst) begin
                m_left[g] = 0;
                m_done[g] = 1'b0;
                m_dout[g] = '0;
            end else begin
                m_done[g] = 1'b0;
                if (m_left[g] > 0) begin
                    m_left[g]--;
                    if (m_left[g] == 0) begin
                        m_dout[g] = m_pend[g];
                        m_done[g] = 1'b1;
                    end
                end else if (start_s) begin
                    n = (op_s == 2'b11 || shamt_s == 0) ? 0
                        : (int'(shamt_s) + int'(step_of(g)) - 1) / int'(step_of(g));
                    m_left[g] = n + 1;
                    m_pend[g] = ref_res(op_s, din_s, shamt_s);
                end
            end
        end
    endtask

    task automatic chk(string name, int g, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h want %h at %0t", name, g, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the pre-edge inputs, then compare.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        for (int g = 0; g < NDUT; g++) begin
            chk("busy", g, 32'(busy_a[g]), 32'(m_left[g] > 0));
            chk("done", g, 32'(done_a[g]), 32'(m_done[g]));
            chk("dout", g, dout_a[g], m_dout[g]);
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((busy_a[0] || busy_a[1] || busy_a[2]) && k < 100) begin
            cycle();
            k++;
        end
        chk("drain_idle", 0, 32'(busy_a[0] || busy_a[1] || busy_a[2]), 32'd0);
    endtask

    // Single operation with literal result/latency/busy-length checks on one DUT.
    task automatic run_op(string name, int idx, logic [1:0] op, logic [31:0] d,
                          logic [4:0] sh, logic [31:0] exp_dout, int exp_lat);
        int lat;
        int nbusy;
        drain();
        start_s = 1'b1; op_s = op; din_s = d; shamt_s = sh;
        cycle();
        start_s = 1'b0;
        lat = 1;
        nbusy = 0;
        while (!done_a[idx] && lat < 80) begin
            if (busy_a[idx]) nbusy++;
            din_s = $urandom; shamt_s = 5'($urandom); op_s = 2'($urandom);
            cycle();
            lat++;
        end
        chk({name, "_done"}, idx, 32'(done_a[idx]), 32'd1);
        chk({name, "_lat"}, idx, 32'(lat), 32'(exp_lat));
        chk({name, "_busylen"}, idx, 32'(nbusy), 32'(exp_lat - 1));
        chk({name, "_dout"}, idx, dout_a[idx], exp_dout);
    endtask

    initial begin
        int lat;
        int ndone;
        for (int g = 0; g < NDUT; g++) begin
            m_left[g] = 0; m_pend[g] = '0; m_dout[g] = '0; m_done[g] = 1'b0;
        end

        rst = 1'b1;
        cycle();
        cycle();
        for (int g = 0; g < NDUT; g++) begin
            chk("rst_busy", g, 32'(busy_a[g]), 32'd0);
            chk("rst_done", g, 32'(done_a[g]), 32'd0);
            chk("rst_dout", g, dout_a[g], 32'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        chk("idle_dout", 0, dout_a[0], 32'h0);

        run_op("sll4_s1",   0, 2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010, 6);
        run_op("sra2_s4",   1, 2'b10, 32'hFFFF_FFF8, 5'd2,  32'hFFFF_FFFE, 3);
        run_op("srl31_s4",  1, 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 10);
        run_op("sh0_s1",    0, 2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678, 2);
        run_op("rsv_s1",    0, 2'b11, 32'hCAFE_F00D, 5'd7,  32'hCAFE_F00D, 2);
        run_op("sra31_s16", 2, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 4);
        run_op("sll31_s16", 2, 2'b00, 32'h0000_0003, 5'd31, 32'h8000_0000, 4);

        // Start while busy is ignored; start in the done cycle is accepted.
        drain();
        start_s = 1'b1; op_s = 2'b00; din_s = 32'h1; shamt_s = 5'd8;
        cycle();
        start_s = 1'b0;
        cycle();
        cycle();
        start_s = 1'b1; din_s = 32'hFFFF_FFFF; shamt_s = 5'd3;
        cycle();
        start_s = 1'b0;
        lat = 4;
        while (!done_a[0] && lat < 80) begin
            cycle();
            lat++;
        end
        chk("busy_start_lat", 0, 32'(lat), 32'd10);
        chk("busy_start_dout", 0, dout_a[0], 32'h0000_0100);
        start_s = 1'b1; op_s = 2'b01; din_s = 32'h0000_0100; shamt_s = 5'd4;
        cycle();
        start_s = 1'b0;
        chk("done_cycle_accept", 0, 32'(busy_a[0]), 32'd1);
        lat = 1;
        while (!done_a[0] && lat < 80) begin
            cycle();
            lat++;
        end
        chk("done_cycle_lat", 0, 32'(lat), 32'd6);
        chk("done_cycle_dout", 0, dout_a[0], 32'h0000_0010);

        // Reset mid-operation discards the operation.
        drain();
        start_s = 1'b1; op_s = 2'b01; din_s = 32'h8000_0000; shamt_s = 5'd20;
        cycle();
        start_s = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            chk("midrst_busy", g, 32'(busy_a[g]), 32'd0);
            chk("midrst_done", g, 32'(done_a[g]), 32'd0);
            chk("midrst_dout", g, dout_a[g], 32'h0);
        end
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (done_a[0]) ndone++;
        end
        chk("midrst_nodone", 0, 32'(ndone), 32'd0);
        run_op("post_rst", 0, 2'b01, 32'h8000_0000, 5'd20, 32'h0000_0800, 22);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            start_s = ($urandom_range(0, 2) == 0);
            op_s    = 2'($urandom);
            din_s   = $urandom;
            case ($urandom_range(0, 7))
                0:       shamt_s = 5'd0;
                1:       shamt_s = 5'd31;
                default: shamt_s = 5'($urandom);
            endcase
            cycle();
        end
        rst = 1'b0;
        start_s = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
